data_bus_arbiter: RTL and testbench

Round-robin arbiter for the shared MiniRISC data-memory bus. The CPU controller (`bus_req`/`bus_grant`), the DMA engine and the debug port request the bus through this block, and it grants exactly one owner at a time. An optional per-master lock keeps ownership across multi-cycle sequences such as stack push/pop bursts. A hold-time limit stops an unlocked master from starving the others.

---
 rtl/data_bus_arbiter.sv | 119 +++++++++++
 tb/tb_data_bus_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin owner selection for the shared data-memory bus.
// A per-master lock keeps ownership across multi-cycle sequences, and a hold
// limit hands the bus on from an unlocked owner that has had it long enough
// while someone else is waiting.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - asynchronous, active-high reset
//   req      - bus request, one bit per master (bit 0 = CPU)
//   lock     - lock request, only the current owner's bit is looked at
//   grant    - one-hot (or zero) grant, gated by the owner's live request
//   owner    - index of the last or current owner
//   bus_busy - high while any grant is high
module data_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_HOLD    = 8,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] lock,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       owner,
    output logic                   bus_busy
);

    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   state;
    logic [NUM_MASTERS-1:0]   own_oh;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     active;

    logic                     owner_req;
    logic                     owner_lock;
    logic [NUM_MASTERS-1:0]   cand;
    logic                     pick_valid;
    logic [IDX_W-1:0]         pick_idx;
    logic [NUM_MASTERS-1:0]   pick_oh;

    assign active = (state == GRANT);

    // Grant is gated by the live request so a releasing owner drops it at once.
    assign grant    = own_oh & req & {NUM_MASTERS{active}};
    assign bus_busy = |grant;

    // own_oh is zero while idle, so one candidate mask serves both states:
    // idle searches everyone, granted searches everyone but the owner.
    always_comb begin
        owner_req  = |(req & own_oh);
        owner_lock = |(lock & own_oh);
        cand       = req & ~own_oh;
        pick_valid = 1'b0;
        pick_idx   = owner;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            if (!pick_valid && cand[IDX_W'((32'(owner) + i) % NUM_MASTERS)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((32'(owner) + i) % NUM_MASTERS);
            end
        end
        pick_oh = NUM_MASTERS'(1) << pick_idx;
    end

    // Arbitration state machine; a handover always clears the hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            own_oh   <= '0;
            owner    <= IDX_W'(NUM_MASTERS - 1);
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state    <= GRANT;
                        own_oh   <= pick_oh;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        if (pick_valid) begin
                            own_oh   <= pick_oh;
                            owner    <= pick_idx;
                            hold_cnt <= '0;
                        end else begin
                            state    <= IDLE;
                            own_oh   <= '0;
                            hold_cnt <= '0;
                        end
                    end else if (!owner_lock && pick_valid && (hold_cnt >= HOLD_LAST)) begin
                        // >= rather than == so an owner whose count saturated
                        // under lock is handed over as soon as the lock drops.
                        own_oh   <= pick_oh;
                        owner    <= pick_idx;
                        hold_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= HOLD_W'(hold_cnt + HOLD_W'(1));
                    end
                end
                default: begin
                    state    <= IDLE;
                    own_oh   <= '0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed request/lock vectors with hand-computed
// grant expectations, plus a behavioural model checked on every falling edge.
module tb_data_bus_arbiter;

    localparam int unsigned NM   = 4;
    localparam int unsigned HOLD = 8;
    localparam int unsigned IW   = $clog2(NM);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NM-1:0] req = '0;
    logic [NM-1:0] lock = '0;
    logic [NM-1:0] grant;
    logic [IW-1:0] owner;
    logic          bus_busy;

    data_bus_arbiter #(
        .NUM_MASTERS (NM),
        .MAX_HOLD    (HOLD),
        .IDX_W       (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .grant    (grant),
        .owner    (owner),
        .bus_busy (bus_busy)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Behavioural model: who owns the bus, whether it is held, and how many
    // cycles in a row the owner has been granted (unbounded count).
    int m_owner = NM - 1;
    bit m_busy  = 1'b0;
    int m_held  = 0;
    int w;
    int held_now;

    function automatic int rr_next(input logic [NM-1:0] r, input int from, input bit skip_from);
        int res;
        res = -1;
        for (int k = 1; k <= NM; k++) begin
            int m;
            m = (from + k) % NM;
            if (res < 0 && r[m] && !(skip_from && m == from)) res = m;
        end
        return res;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= NM - 1;
            m_busy  <= 1'b0;
            m_held  <= 0;
        end else if (!m_busy) begin
            w = rr_next(req, m_owner, 1'b0);
            if (w >= 0) begin
                m_owner <= w;
                m_busy  <= 1'b1;
                m_held  <= 0;
            end
        end else if (!req[m_owner]) begin
            w = rr_next(req, m_owner, 1'b1);
            if (w >= 0) begin
                m_owner <= w;
                m_held  <= 0;
            end else begin
                m_busy  <= 1'b0;
                m_held  <= 0;
            end
        end else begin
            held_now = m_held + 1;
            w = rr_next(req, m_owner, 1'b1);
            if (!lock[m_owner] && w >= 0 && held_now >= int'(HOLD)) begin
                m_owner <= w;
                m_held  <= 0;
            end else begin
                m_held  <= held_now;
            end
        end
    end

    // Literal expectation posted by the stimulus for the next falling edge.
    bit            cmp_en    = 1'b0;
    bit            lit_en    = 1'b0;
    logic [NM-1:0] lit_grant = '0;
    int            lit_owner = -1;
    string         lit_name  = "";

    logic [NM-1:0] exp_grant;

    always @(negedge clk) begin
        if (cmp_en) begin
            exp_grant = (m_busy && req[m_owner]) ? NM'(1) << m_owner : '0;
            vecs++;
            if (grant !== exp_grant || owner !== IW'(m_owner) || bus_busy !== (exp_grant != '0)) begin
                errs++;
                $display("FAIL model t=%0t: grant=%b owner=%0d busy=%b, required grant=%b owner=%0d busy=%b",
                         $time, grant, owner, bus_busy, exp_grant, m_owner, exp_grant != '0);
            end
        end
        if (lit_en) begin
            vecs++;
            if (grant !== lit_grant || bus_busy !== (lit_grant != '0) ||
                (lit_owner >= 0 && owner !== IW'(lit_owner))) begin
                errs++;
                $display("FAIL %s t=%0t: grant=%b owner=%0d busy=%b, required grant=%b owner=%0d busy=%b",
                         lit_name, $time, grant, owner, bus_busy, lit_grant, lit_owner, lit_grant != '0);
            end
        end
    end

    // Apply inputs just after a falling edge; expect g in the following cycle.
    task automatic vec(input logic [NM-1:0] r, input logic [NM-1:0] l,
                       input logic [NM-1:0] g, input int own, input string nm);
        req       = r;
        lock      = l;
        lit_en    = 1'b1;
        lit_grant = g;
        lit_owner = own;
        lit_name  = nm;
        @(negedge clk);
        #1 lit_en = 1'b0;
    endtask

    task automatic do_reset();
        req       = '0;
        lock      = '0;
        rst       = 1'b1;
        lit_en    = 1'b1;
        lit_grant = '0;
        lit_owner = NM - 1;
        lit_name  = "reset_state";
        @(negedge clk);
        #1;
        lit_en = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        cmp_en = 1'b1;
        do_reset();

        // First request after reset: master 0 in one cycle.
        vec(4'b0001, 4'b0000, 4'b0001, 0, "first_req");
        vec(4'b0000, 4'b0000, 4'b0000, 0, "first_idle");

        // All request; each drops right after its grant: 0,1,2,3,0 with no gaps.
        do_reset();
        vec(4'b1111, 4'b0000, 4'b0001, 0, "rr_m0");
        vec(4'b1110, 4'b0000, 4'b0010, 1, "rr_m1");
        vec(4'b1100, 4'b0000, 4'b0100, 2, "rr_m2");
        vec(4'b1000, 4'b0000, 4'b1000, 3, "rr_m3");
        vec(4'b0001, 4'b0000, 4'b0001, 0, "rr_m0_again");
        vec(4'b0000, 4'b0000, 4'b0000, 0, "rr_idle");

        // Contended, unlocked: eight cycles each, then back to master 0.
        do_reset();
        for (int i = 0; i < 8; i++) vec(4'b0011, 4'b0000, 4'b0001, 0, "preempt_m0");
        for (int i = 0; i < 8; i++) vec(4'b0011, 4'b0000, 4'b0010, 1, "preempt_m1");
        vec(4'b0011, 4'b0000, 4'b0001, 0, "preempt_back_m0");

        // Owner lock blocks preemption; dropping it hands over on the next edge.
        do_reset();
        for (int i = 0; i < 22; i++) vec(4'b0011, 4'b0001, 4'b0001, 0, "lock_hold");
        vec(4'b0011, 4'b0000, 4'b0010, 1, "lock_release");
        vec(4'b0011, 4'b0000, 4'b0010, 1, "lock_after");

        // A non-owner's lock bit has no effect on the owner's preemption.
        do_reset();
        for (int i = 0; i < 8; i++) vec(4'b0011, 4'b0010, 4'b0001, 0, "foreign_lock_m0");
        vec(4'b0011, 4'b0010, 4'b0010, 1, "foreign_lock_m1");

        // Single requester for 3 cycles, then idle with owner kept.
        do_reset();
        for (int i = 0; i < 3; i++) vec(4'b0100, 4'b0000, 4'b0100, 2, "single_m2");
        vec(4'b0000, 4'b0000, 4'b0000, 2, "release_idle");
        vec(4'b0101, 4'b0000, 4'b0001, 0, "rr_from_3");
        vec(4'b0000, 4'b0000, 4'b0000, 0, "rr_from_3_idle");

        // Uncontended owner keeps the bus well past the hold limit.
        do_reset();
        for (int i = 0; i < 20; i++) vec(4'b1000, 4'b0000, 4'b1000, 3, "uncontended");
        vec(4'b0000, 4'b0000, 4'b0000, 3, "uncontended_idle");

        // Reset in the middle of a grant drops grant in the same cycle.
        do_reset();
        vec(4'b0010, 4'b0000, 4'b0010, 1, "pre_reset_grant");
        @(posedge clk);
        #2;
        rst       = 1'b1;
        lit_en    = 1'b1;
        lit_grant = '0;
        lit_owner = NM - 1;
        lit_name  = "reset_mid_grant";
        @(negedge clk);
        #1;
        lit_en = 1'b0;
        rst    = 1'b0;
        vec(4'b0010, 4'b0000, 4'b0010, 1, "after_reset_grant");
        vec(4'b0000, 4'b0000, 4'b0000, 1, "end_idle");

        cmp_en = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
